// File: rtl/pifo_result_pkg.sv
// Shared types and width helpers for the PIFO pop-result merge slice.
// The result struct below describes the default configuration. Modules with
// overridden parameters build a struct of the same shape from their own widths.
package pifo_result_pkg;

   localparam int DEF_PTW      = 16;
   localparam int DEF_MTW      = 0;
   localparam int DEF_TREE_NUM = 4;
   localparam int DEF_LEVEL    = 4;

   // A $clog2 that never returns 0, so a single tree or a single port
   // still gets a 1-bit field.
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   localparam int TREE_NUM_BITS = clog2_min1(DEF_TREE_NUM);
   localparam int LEVEL_BITS    = clog2_min1(DEF_LEVEL);

   typedef struct packed {
      logic [TREE_NUM_BITS-1:0]     tree_id;
      logic [DEF_MTW+DEF_PTW-1:0]   pop_data;
   } result_t;

endpackage

// File: rtl/result_buf.sv
// Per-port result FIFO. A write into a full buffer is accepted only if the
// head is read in the same cycle. Otherwise the write is dropped and the
// sticky overflow flag is set. DEPTH must be a power of two (>= 2), so the
// pointers wrap naturally.
module result_buf #(
   parameter int W     = 18,
   parameter int DEPTH = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_wr,
   input  logic [W-1:0] i_wdata,
   input  logic         i_rd,
   output logic [W-1:0] o_rdata,
   output logic         o_empty,
   output logic         o_full,
   output logic         o_overflow
);

   localparam int AW = (DEPTH <= 1) ? 1 : $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic          rd_acc;
   logic          wr_acc;

   assign o_empty = (count_q == '0);
   assign o_full  = (count_q == (AW+1)'(DEPTH));
   assign rd_acc  = i_rd & ~o_empty;
   assign wr_acc  = i_wr & (~o_full | rd_acc);
   assign o_rdata = mem[rd_ptr_q];

   // Storage, pointers, occupancy and the sticky drop flag
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         o_overflow <= 1'b0;
      end else begin
         if (wr_acc) begin
            mem[wr_ptr_q] <= i_wdata;
            wr_ptr_q      <= wr_ptr_q + 1'b1;
         end
         if (rd_acc) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};
         if (i_wr & o_full & ~rd_acc) o_overflow <= 1'b1;
      end
   end

endmodule

// File: rtl/pop_result_merge.sv
// Merges the level-0 pop results of LEVEL RPU ports into one registered
// valid/ready stream. Each port has its own result_buf. A round-robin
// arbiter then picks which non-empty buffer loads the output register.
// Optional feature: define POP_RESULT_EMPTY_FILTER_EN to drop all-ones
// (empty tree) results at capture and count them in o_empty_cnt.
//
// Handshake: o_valid/o_tree_id/o_pop_data/o_src_level are held stable while
// o_valid=1 and i_ready=0. A result is transferred on a rising edge where
// o_valid=1 and i_ready=1. The output register may reload on that same edge.
module pop_result_merge
   import pifo_result_pkg::*;
#(
   parameter int PTW      = 16,
   parameter int MTW      = 0,
   parameter int CTW      = 10,
   parameter int LEVEL    = 4,
   parameter int TREE_NUM = 4,
   parameter int BUF_SIZE = 4
) (
   input  logic                                           i_clk,
   input  logic                                           i_rst,
   input  logic [LEVEL-1:0]                               i_is_level0_pop,
   input  logic [LEVEL-1:0][clog2_min1(TREE_NUM)-1:0]     i_tree_id,
   input  logic [LEVEL-1:0][MTW+PTW-1:0]                  i_pop_data,
   output logic                                           o_valid,
   input  logic                                           i_ready,
   output logic [clog2_min1(TREE_NUM)-1:0]                o_tree_id,
   output logic [MTW+PTW-1:0]                             o_pop_data,
   output logic [clog2_min1(LEVEL)-1:0]                   o_src_level,
   output logic [LEVEL-1:0]                               o_buf_full,
   output logic [LEVEL-1:0]                               o_overflow,
   output logic [CTW-1:0]                                 o_empty_cnt
);

   localparam int TB = clog2_min1(TREE_NUM);
   localparam int LB = clog2_min1(LEVEL);
   localparam int DW = MTW + PTW;
   localparam int RW = TB + DW;

   typedef struct packed {
      logic [TB-1:0] tree_id;
      logic [DW-1:0] pop_data;
   } res_t;

   logic [LEVEL-1:0] is_empty_res;
   logic [LEVEL-1:0] cap_en;
   logic [LEVEL-1:0] buf_empty;
   logic [LEVEL-1:0] buf_rd;
   logic [RW-1:0]    buf_head [LEVEL];

   logic [LB-1:0]    rr_ptr_q;
   logic [LB-1:0]    grant_idx;
   logic             grant_vld;
   logic             load;
   logic             take;
   res_t             head;

   // Per-port capture qualification (empty-tree results never enter a buffer)
   always_comb begin
      for (int p = 0; p < LEVEL; p++) begin
`ifdef POP_RESULT_EMPTY_FILTER_EN
         is_empty_res[p] = i_is_level0_pop[p] & (&i_pop_data[p]);
`else
         is_empty_res[p] = 1'b0;
`endif
         cap_en[p] = i_is_level0_pop[p] & ~is_empty_res[p];
      end
   end

   for (genvar p = 0; p < LEVEL; p++) begin : g_buf
      result_buf #(
         .W     (RW),
         .DEPTH (BUF_SIZE)
      ) u_buf (
         .i_clk      (i_clk),
         .i_rst      (i_rst),
         .i_wr       (cap_en[p]),
         .i_wdata    ({i_tree_id[p], i_pop_data[p]}),
         .i_rd       (buf_rd[p]),
         .o_rdata    (buf_head[p]),
         .o_empty    (buf_empty[p]),
         .o_full     (o_buf_full[p]),
         .o_overflow (o_overflow[p])
      );
   end

   // Round-robin pick of the first non-empty buffer at or after rr_ptr_q
   always_comb begin
      int idx;
      idx       = 0;
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int i = 0; i < LEVEL; i++) begin
         idx = (int'(rr_ptr_q) + i) % LEVEL;
         if (!grant_vld && !buf_empty[idx]) begin
            grant_vld = 1'b1;
            grant_idx = LB'(idx);
         end
      end
      load = ~o_valid | i_ready;
      take = load & grant_vld;
      for (int p = 0; p < LEVEL; p++) buf_rd[p] = take && (grant_idx == LB'(p));
      head = res_t'(buf_head[grant_idx]);
   end

   // Output register and arbitration pointer (pointer moves only on a grant)
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_valid     <= 1'b0;
         o_tree_id   <= '0;
         o_pop_data  <= '0;
         o_src_level <= '0;
         rr_ptr_q    <= '0;
      end else if (load) begin
         o_valid <= grant_vld;
         if (grant_vld) begin
            o_tree_id   <= head.tree_id;
            o_pop_data  <= head.pop_data;
            o_src_level <= grant_idx;
            rr_ptr_q    <= (grant_idx == LB'(LEVEL-1)) ? '0 : grant_idx + 1'b1;
         end
      end
   end

`ifdef POP_RESULT_EMPTY_FILTER_EN
   // Count filtered empty-tree results, saturating at all ones
   always_ff @(posedge i_clk) begin
      logic [CTW-1:0] cnt;
      if (i_rst) begin
         o_empty_cnt <= '0;
      end else begin
         cnt = o_empty_cnt;
         for (int p = 0; p < LEVEL; p++)
            if (is_empty_res[p] && cnt != {CTW{1'b1}}) cnt = cnt + 1'b1;
         o_empty_cnt <= cnt;
      end
   end
`else
   assign o_empty_cnt = '0;
`endif

endmodule

// File: tb/tb_pop_result_merge.sv
// Bench for pop_result_merge (default parameters). A queue-level model
// predicts the outputs every cycle. An ordered expected queue checks the
// accepted results, and directed literals pin the model.
// Honours POP_RESULT_EMPTY_FILTER_EN the same way as the design.
module tb_pop_result_merge;

   localparam int PTW = 16, MTW = 0, CTW = 10, LEVEL = 4, TREE_NUM = 4, BUF_SIZE = 4;
   localparam int TB = 2, LB = 2, DW = MTW + PTW;
`ifdef POP_RESULT_EMPTY_FILTER_EN
   localparam bit FILTER = 1'b1;
`else
   localparam bit FILTER = 1'b0;
`endif

   // ---------------- clock / reset / stimulus signals ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [LEVEL-1:0]          strobe  = '0;
   logic [LEVEL-1:0][TB-1:0]  tree_in = '0;
   logic [LEVEL-1:0][DW-1:0]  data_in = '0;
   logic                      ready   = 1'b0;

   logic              o_valid;
   logic [TB-1:0]     o_tree_id;
   logic [DW-1:0]     o_pop_data;
   logic [LB-1:0]     o_src_level;
   logic [LEVEL-1:0]  o_buf_full;
   logic [LEVEL-1:0]  o_overflow;
   logic [CTW-1:0]    o_empty_cnt;

   always #5 clk = ~clk;

   pop_result_merge #(
      .PTW(PTW), .MTW(MTW), .CTW(CTW), .LEVEL(LEVEL), .TREE_NUM(TREE_NUM), .BUF_SIZE(BUF_SIZE)
   ) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_is_level0_pop (strobe),
      .i_tree_id       (tree_in),
      .i_pop_data      (data_in),
      .o_valid         (o_valid),
      .i_ready         (ready),
      .o_tree_id       (o_tree_id),
      .o_pop_data      (o_pop_data),
      .o_src_level     (o_src_level),
      .o_buf_full      (o_buf_full),
      .o_overflow      (o_overflow),
      .o_empty_cnt     (o_empty_cnt)
   );

   // ---------------- check bookkeeping ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic fail_now(input string name, input int val);
      n_checks++;
      $display("FAIL %s: value %0d (t=%0t)", name, val, $time);
   endtask

   // ---------------- behavioural model ----------------
   logic [TB+DW-1:0] mq [LEVEL][$];
   bit               m_valid = 1'b0;
   logic [TB-1:0]    m_tree  = '0;
   logic [DW-1:0]    m_data  = '0;
   int               m_src   = 0;
   int               m_rr    = 0;
   bit [LEVEL-1:0]   m_ovf   = '0;
   int               m_ecnt  = 0;

   always @(posedge clk) begin
      int g;
      logic [TB+DW-1:0] hd;
      if (rst) begin
         for (int p = 0; p < LEVEL; p++) mq[p].delete();
         m_valid = 1'b0; m_tree = '0; m_data = '0; m_src = 0;
         m_rr = 0; m_ovf = '0; m_ecnt = 0;
      end else begin
         g = -1;
         if (!m_valid || ready) begin
            for (int i = 0; i < LEVEL; i++)
               if (g < 0 && mq[(m_rr + i) % LEVEL].size() > 0) g = (m_rr + i) % LEVEL;
            if (g >= 0) begin
               hd      = mq[g].pop_front();
               m_valid = 1'b1;
               m_tree  = hd[TB+DW-1:DW];
               m_data  = hd[DW-1:0];
               m_src   = g;
               m_rr    = (g + 1) % LEVEL;
            end else begin
               m_valid = 1'b0;
            end
         end
         for (int p = 0; p < LEVEL; p++) begin
            if (strobe[p]) begin
               if (FILTER && data_in[p] == '1) begin
                  if (m_ecnt < (1 << CTW) - 1) m_ecnt++;
               end else if (mq[p].size() < BUF_SIZE) begin
                  mq[p].push_back({tree_in[p], data_in[p]});
               end else begin
                  m_ovf[p] = 1'b1;
               end
            end
         end
      end
   end

   // Per-cycle compare against the model (sampled mid-cycle)
   always @(negedge clk) begin
      chk("valid", o_valid, m_valid);
      if (m_valid) begin
         chk("tree_id", o_tree_id, m_tree);
         chk("pop_data", o_pop_data, m_data);
         chk("src_level", o_src_level, m_src);
      end
      for (int p = 0; p < LEVEL; p++) chk("buf_full", o_buf_full[p], mq[p].size() == BUF_SIZE);
      chk("overflow", o_overflow, m_ovf);
      chk("empty_cnt", o_empty_cnt, m_ecnt);
   end

   // ---------------- ordered scoreboard of accepted results ----------------
   logic [LB+TB+DW-1:0] exp_q [$];

   always @(negedge clk) begin
      logic [LB+TB+DW-1:0] e;
      if (!rst && o_valid && ready) begin
         if (exp_q.size() == 0) begin
            fail_now("sb_unexpected", int'(o_pop_data));
         end else begin
            e = exp_q.pop_front();
            chk("sb_result", {o_src_level, o_tree_id, o_pop_data}, e);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      strobe = '0;
      step();
      rst    = 1'b0;
      exp_q.delete();
   endtask

   task automatic push_exp(input int src, input int tree, input int data);
      exp_q.push_back({LB'(src), TB'(tree), DW'(data)});
   endtask

   task automatic strobe_one(input int port, input int tree, input int data);
      strobe          = '0;
      strobe[port]    = 1'b1;
      tree_in[port]   = TB'(tree);
      data_in[port]   = DW'(data);
      step();
      strobe          = '0;
   endtask

   task automatic drain(input int max_cycles);
      for (int i = 0; i < max_cycles && exp_q.size() > 0; i++) step();
      if (exp_q.size() != 0) fail_now("drain_timeout", exp_q.size());
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      chk("rst_valid", o_valid, 0);
      chk("rst_tree", o_tree_id, 0);
      chk("rst_data", o_pop_data, 0);
      chk("rst_src", o_src_level, 0);
      chk("rst_ovf", o_overflow, 0);

      // Single result: port 2, tree 1, data 0x0005, two-cycle latency
      ready = 1'b1;
      push_exp(2, 1, 16'h0005);
      strobe_one(2, 1, 16'h0005);
      chk("lat_n1_valid", o_valid, 0);
      step();
      chk("lat_n2_valid", o_valid, 1);
      chk("lat_tree", o_tree_id, 1);
      chk("lat_data", o_pop_data, 16'h0005);
      chk("lat_src", o_src_level, 2);
      drain(10);

      // Fairness: all ports strobe for 4 cycles, grants rotate 0,1,2,3
      do_reset();
      ready = 1'b1;
      for (int r = 0; r < 4; r++)
         for (int p = 0; p < LEVEL; p++) push_exp(p, p, 16'h0100 * p + r);
      for (int r = 0; r < 4; r++) begin
         for (int p = 0; p < LEVEL; p++) begin
            strobe[p]  = 1'b1;
            tree_in[p] = TB'(p);
            data_in[p] = DW'(16'h0100 * p + r);
         end
         step();
      end
      strobe = '0;
      chk("fair_first_src", o_src_level, 2);
      drain(40);
      chk("fair_no_ovf", o_overflow, 0);

      // Backpressure: six strobes on port 0, one fills the output, one drops
      do_reset();
      ready = 1'b0;
      for (int k = 0; k < 6; k++) strobe_one(0, 1, 16'h0010 + k);
      chk("bp_full", o_buf_full[0], 1);
      chk("bp_ovf", o_overflow[0], 1);
      chk("bp_hold_data", o_pop_data, 16'h0010);
      step();
      chk("bp_hold_data2", o_pop_data, 16'h0010);
      for (int k = 0; k < 5; k++) push_exp(0, 1, 16'h0010 + k);
      ready = 1'b1;
      drain(20);
      chk("bp_ovf_sticky", o_overflow[0], 1);
      chk("bp_full_clear", o_buf_full[0], 0);

      // Full buffer with a same-cycle read accepts the new entry
      do_reset();
      ready = 1'b0;
      for (int k = 0; k < 5; k++) strobe_one(1, 3, 16'h0020 + k);
      chk("fr_full", o_buf_full[1], 1);
      for (int k = 0; k < 6; k++) push_exp(1, 3, 16'h0020 + k);
      ready = 1'b1;
      strobe_one(1, 3, 16'h0025);
      chk("fr_no_ovf", o_overflow[1], 0);
      chk("fr_still_full", o_buf_full[1], 1);
      drain(20);
      chk("fr_no_ovf_end", o_overflow[1], 0);

      // All-ones result: filtered and counted, or forwarded
      do_reset();
      ready = 1'b1;
      if (!FILTER) push_exp(1, 2, 16'hFFFF);
      strobe_one(1, 2, 16'hFFFF);
      step();
      chk("flt_valid", o_valid, FILTER ? 0 : 1);
      chk("flt_cnt", o_empty_cnt, FILTER ? 1 : 0);
      if (!FILTER) chk("flt_data", o_pop_data, 16'hFFFF);
      drain(10);

      // Reset mid-stream with results buffered
      do_reset();
      ready = 1'b0;
      for (int k = 0; k < 4; k++) strobe_one(0, 0, 16'h0030 + k);
      chk("rm_valid_before", o_valid, 1);
      rst        = 1'b1;
      ready      = 1'b1;
      strobe[3]  = 1'b1;
      data_in[3] = 16'h0077;
      step();
      rst    = 1'b0;
      strobe = '0;
      exp_q.delete();
      chk("rm_valid", o_valid, 0);
      chk("rm_ovf", o_overflow, 0);
      chk("rm_cnt", o_empty_cnt, 0);
      chk("rm_full", o_buf_full, 0);
      for (int i = 0; i < 6; i++) begin
         step();
         chk("rm_no_stale", o_valid, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
